// File: rtl/stoch_pkg.sv
// rtl/stoch_pkg.sv - shared stream-generator state encoding and default widths
package stoch_pkg;

  localparam int PROB_W_DEF = 16;
  localparam int LEN_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sng_cmp.sv
// rtl/sng_cmp.sv - stochastic bit: top PROB_W bits of the random word compared against the probability
module sng_cmp #(
  parameter int PROB_W = 16
) (
  input  logic [31:0]       rnd_i,
  input  logic [PROB_W-1:0] prob_i,
  output logic              bit_o
);

  assign bit_o = (rnd_i[31 -: PROB_W] < prob_i);

  // Only the upper field carries the draw; the remaining low bits are intentionally dropped.
  generate
    if (PROB_W < 32) begin : g_low_bits
      logic rnd_low_unused;
      assign rnd_low_unused = ^rnd_i[31-PROB_W:0];
    end
  endgenerate

endmodule

// File: rtl/sng_stream.sv
// rtl/sng_stream.sv - length-bounded stochastic bit stream with valid/ready output and ones counter
module sng_stream
  import stoch_pkg::*;
#(
  parameter int PROB_W = PROB_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       rnd,
  input  logic [PROB_W-1:0] prob,
  input  logic [LEN_W-1:0]  len,
  input  logic              start,
  output logic              busy,
  output logic              bit_out,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic              done,
  output logic [LEN_W-1:0]  ones_cnt
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_e            state_q;
  logic [PROB_W-1:0] prob_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued_q;
  logic [LEN_W-1:0]  accepted_q;
  logic [LEN_W-1:0]  ones_q;
  logic              bit_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;

  logic new_bit;
  logic hs;
  logic load;
  logic last_hs;

  sng_cmp #(
    .PROB_W (PROB_W)
  ) u_cmp (
    .rnd_i  (rnd),
    .prob_i (prob_q),
    .bit_o  (new_bit)
  );

  assign hs      = valid_q && bit_ready;
  assign load    = (!valid_q || bit_ready) && (issued_q < len_q);
  // accepted_q < len_q whenever a beat is pending, so the increment cannot wrap.
  assign last_hs = hs && ((accepted_q + ONE) == len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      prob_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      ones_q     <= '0;
      bit_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            prob_q     <= prob;
            len_q      <= len;
            issued_q   <= '0;
            accepted_q <= '0;
            ones_q     <= '0;
            busy_q     <= 1'b1;
            if (len != '0) begin
              state_q <= ST_RUN;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (hs) begin
            accepted_q <= accepted_q + ONE;
            if (bit_q) begin
              ones_q <= ones_q + ONE;
            end
          end
          if (last_hs) begin
            valid_q <= 1'b0;
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else if (load) begin
            bit_q    <= new_bit;
            valid_q  <= 1'b1;
            issued_q <= issued_q + ONE;
          end else if (hs) begin
            valid_q <= 1'b0;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign bit_out   = bit_q;
  assign bit_valid = valid_q;
  assign done      = done_q;
  assign ones_cnt  = ones_q;

endmodule

// File: tb/tb_sng_stream.sv
// tb/tb_sng_stream.sv - randomized self-checking bench for sng_stream against a beat-schedule model
module tb_sng_stream;

  localparam int NMAX = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rnd = '0;
  logic [15:0] prob = '0;
  logic [15:0] len = '0;
  logic        start = 1'b0;
  logic        busy;
  logic        bit_out;
  logic        bit_valid;
  logic        bit_ready = 1'b0;
  logic        done;
  logic [15:0] ones_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] t1, t2, t3;
  logic [31:0] rnd_a [NMAX];
  logic        rdy_a [NMAX];
  int          draw_t [NMAX];
  int          acc_t [NMAX];
  logic        bit_e [NMAX];

  sng_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rnd       (rnd),
    .prob      (prob),
    .len       (len),
    .start     (start),
    .busy      (busy),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .done      (done),
    .ones_cnt  (ones_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic taus(output logic [31:0] r);
    logic [31:0] b;
    b  = ((t1 << 13) ^ t1) >> 19;
    t1 = ((t1 & 32'hFFFF_FFFE) << 12) ^ b;
    b  = ((t2 << 2) ^ t2) >> 25;
    t2 = ((t2 & 32'hFFFF_FFF8) << 4) ^ b;
    b  = ((t3 << 3) ^ t3) >> 11;
    t3 = ((t3 & 32'hFFFF_FFF0) << 17) ^ b;
    r  = t1 ^ t2 ^ t3;
  endtask

  // Beat k is drawn at edge draw_t[k] (edge 0 = start edge) and accepted at the first
  // later edge with ready high; the next beat is drawn on that same edge.
  task automatic run_stream(input logic [15:0] p, input logic [15:0] l, input int rmode,
                            input int ymode, input int stall_at, input int cut_at);
    int          t;
    int          last;
    int          cur;
    logic [15:0] ones_e;
    for (int i = 0; i < NMAX; i++) begin
      case (rmode)
        0:       rnd_a[i] = $urandom;
        1:       rnd_a[i] = 32'h0000_0000;
        2:       rnd_a[i] = 32'hFFFF_FFFF;
        default: taus(rnd_a[i]);
      endcase
      if (ymode == 0 || i > 300) rdy_a[i] = 1'b1;
      else if (ymode == 1)       rdy_a[i] = ($urandom_range(0, 9) < 7);
      else                       rdy_a[i] = !(i >= stall_at && i < stall_at + 5);
    end
    t = 1;
    for (int k = 0; k < int'(l); k++) begin
      draw_t[k] = t;
      bit_e[k]  = (rnd_a[t][31:16] < p);
      t++;
      while (!rdy_a[t]) t++;
      acc_t[k] = t;
    end
    last = (l == 16'd0) ? 0 : acc_t[int'(l) - 1];

    prob      = p;
    len       = l;
    start     = 1'b1;
    rnd       = rnd_a[0];
    bit_ready = rdy_a[0];
    for (int e = 0; e <= last + 1; e++) begin
      if (e > 0) begin
        rnd       = rnd_a[e];
        bit_ready = rdy_a[e];
        start     = 1'($urandom_range(0, 1));
        prob      = 16'($urandom);
        len       = 16'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      ones_e = '0;
      cur    = -1;
      for (int k = 0; k < int'(l); k++) begin
        if (acc_t[k] <= e) ones_e = ones_e + 16'(bit_e[k]);
        if (draw_t[k] <= e && e < acc_t[k]) cur = k;
      end
      chk("bit_valid", 32'(bit_valid), 32'(e >= 1 && e < last));
      if (cur >= 0) chk("bit_out", 32'(bit_out), 32'(bit_e[cur]));
      chk("done", 32'(done), 32'(e == last));
      chk("busy", 32'(busy), 32'(e <= last));
      chk("ones_cnt", 32'(ones_cnt), 32'(ones_e));
      if (e == cut_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(bit_valid), 32'd0);
        chk("rst_bit", 32'(bit_out), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ones", 32'(ones_cnt), 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    t1 = 32'hDEAD_BEEF;
    t2 = 32'hDEAD_BEEF * 32'd69069;
    t3 = t2 * 32'd69069;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(bit_valid), 32'd0);
    chk("reset_bit", 32'(bit_out), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_ones", 32'(ones_cnt), 32'd0);
    rst_n = 1'b1;

    run_stream(16'h0000, 16'd8, 0, 0, 0, -1);
    run_stream(16'hFFFF, 16'd5, 1, 0, 0, -1);
    run_stream(16'hFFFF, 16'd6, 2, 0, 0, -1);
    run_stream(16'h1234, 16'd0, 0, 0, 0, -1);
    run_stream(16'h8000, 16'd10, 3, 0, 0, -1);
    run_stream(16'($urandom), 16'd12, 0, 2, 4, -1);
    run_stream(16'hFFFF, 16'd1, 0, 1, 0, -1);
    for (int i = 0; i < 6; i++) begin
      run_stream(16'($urandom), 16'($urandom_range(1, 40)), (i % 2 == 0) ? 0 : 3, 1, 0, -1);
    end
    run_stream(16'h8000, 16'd20, 0, 0, 0, 7);
    run_stream(16'h4000, 16'd3, 0, 0, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sng_stream.md
SNG_STREAM -- requirements
Module: sng_stream

Interface
REQ-001 Parameter PROB_W, default 16: probability/compare width, compared against rnd[31:32-PROB_W].
REQ-002 Parameter LEN_W, default 16: width of stream length and ones counter.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 rnd  input  32  free-running uniform word from the taus88 generator, new value every cycle.
REQ-006 prob  input  PROB_W  target probability; P(bit=1) = prob/2^PROB_W.
REQ-007 len  input  LEN_W  number of bits to emit in the stream.
REQ-008 start  input  1  request a new stream; sampled in IDLE only.
REQ-009 busy  output  1  high in RUN and DONE.
REQ-010 bit_out  output  1  stochastic stream bit.
REQ-011 bit_valid  output  1  bit_out holds a valid beat.
REQ-012 bit_ready  input  1  downstream accepts the beat when valid&&ready.
REQ-013 done  output  1  one-cycle pulse at stream end.
REQ-014 ones_cnt  output  LEN_W  number of accepted 1-beats in the last stream; held until next start.

Function
REQ-015 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-016 IDLE & start: latch prob_q=prob, len_q=len, clear ones_cnt and issue/accept counters; go RUN if len!=0, else DONE.
REQ-017 start outside IDLE is ignored; latched prob_q/len_q do not track input changes during RUN.
REQ-018 Bit rule: bit = (rnd[31:32-PROB_W] < prob_q), unsigned; prob_q=0 gives all zeros; prob_q=all-ones gives 1 except when the rnd field is all-ones.
REQ-019 In RUN, the output register loads a new bit from the current rnd when (!bit_valid || bit_ready) and issued < len_q; the load sets bit_valid=1 and increments issued.
REQ-020 First load occurs on the first clock edge in RUN, so the first bit is derived from the rnd value present in the cycle after start was sampled.
REQ-021 Backpressure: while bit_valid && !bit_ready, bit_out and bit_valid are held stable; rnd words arriving in those cycles are discarded.
REQ-022 Each handshake (bit_valid && bit_ready) increments accepted, and increments ones_cnt if bit_out=1.
REQ-023 When the handshake for beat len_q occurs: bit_valid=0 on the next edge and the FSM enters DONE; no further beats are issued.
REQ-024 DONE lasts exactly one cycle with done=1, then IDLE; ones_cnt is final when done=1.
REQ-025 len=0: done pulses in the cycle after start, with no bit_valid and ones_cnt=0.
REQ-026 Throughput: with bit_ready held high, one beat per cycle; beat k is accepted k cycles after the first beat.
REQ-027 Counters are LEN_W wide; max len (2^LEN_W-1) with all ones yields ones_cnt=2^LEN_W-1 and does not wrap.

Reset
REQ-028 rst_n low asynchronously forces IDLE, busy=0, bit_valid=0, bit_out=0, done=0, ones_cnt=0, and clears all counters, including mid-stream; the partial stream is dropped.
REQ-029 After rst_n deasserts, the first start is honoured on the first rising edge.

Structure
REQ-030 Shared package stoch_pkg holds the FSM state enum and default PROB_W/LEN_W constants.
REQ-031 One sub-module, sng_cmp (combinational compare of rnd field vs prob_q); counters and FSM stay in sng_stream.

Verification
REQ-032 prob=0x0000, len=8, ready=1 -> 8 beats of 0 on consecutive cycles, done pulse, ones_cnt=0.
REQ-033 rnd forced 0x0000_0000, prob=0xFFFF, len=5 -> 5 beats of 1, ones_cnt=5.
REQ-034 len=0, start -> done=1 in the next cycle, bit_valid never high, ones_cnt=0.
REQ-035 Driven by taus88 reseeded with 0xDEADBEEF, start aligned so the first sampled rnd is 3687771566, prob=0x8000, len=10, ready=1 -> bits 0,0,1,0,1,1,0,1,0,0 and ones_cnt=4.
REQ-036 bit_ready low for 5 cycles mid-stream -> bit_out and bit_valid stable throughout, no beat lost or duplicated, total beats = len.
REQ-037 rst_n pulsed low during RUN with len=20 -> outputs cleared immediately; a new start with len=3 completes normally with 3 beats.
